// File: rtl/rf_wr_arbiter.sv
// Two-requester round-robin register-file write arbiter with a zero-fill sequence.
// Optional macro RF_ARB_R0_ZERO_EN: accepted writes to address 0 are dropped.
module rf_wr_arbiter #(
    parameter int unsigned ADDR_LEN = 4,
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [ADDR_LEN-1:0] req0_rd,
    input  logic [ADDR_LEN-1:0] req1_rd,
    input  logic [DATA_LEN-1:0] req0_data,
    input  logic [DATA_LEN-1:0] req1_data,
    input  logic                clear_start,
    output logic                clear_busy,
    output logic                wrt_en,
    output logic [ADDR_LEN-1:0] rd,
    output logic [DATA_LEN-1:0] wrt_data
);

    typedef enum logic {
        ARB,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_LEN-1:0] clr_cnt;
    logic [ADDR_LEN-1:0] clr_cnt_next;
    logic                last_grant1;
    logic                last_grant1_next;
    logic                grant0;
    logic                grant1;
    logic                wrt_en_next;
    logic [ADDR_LEN-1:0] rd_next;
    logic [DATA_LEN-1:0] wrt_data_next;

    always_comb begin
        state_next       = state;
        clr_cnt_next     = clr_cnt;
        last_grant1_next = last_grant1;
        grant0           = 1'b0;
        grant1           = 1'b0;
        clear_busy       = 1'b0;
        wrt_en_next      = 1'b0;
        rd_next          = rd;
        wrt_data_next    = wrt_data;
        case (state)
            ARB: begin
                // A clear request wins over any pending write for this cycle.
                if (!reset && clear_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end else if (!reset) begin
                    grant0 = req0_valid && (!req1_valid || last_grant1);
                    grant1 = req1_valid && (!req0_valid || !last_grant1);
                    if (grant0 || grant1) begin
                        last_grant1_next = grant1;
                        rd_next          = grant1 ? req1_rd : req0_rd;
                        wrt_data_next    = grant1 ? req1_data : req0_data;
`ifdef RF_ARB_R0_ZERO_EN
                        wrt_en_next      = (rd_next != '0);
`else
                        wrt_en_next      = 1'b1;
`endif
                    end
                end
            end
            CLEAR: begin
                clear_busy    = !reset;
                wrt_en_next   = 1'b1;
                rd_next       = clr_cnt;
                wrt_data_next = '0;
                clr_cnt_next  = clr_cnt + 1'b1;
                if (clr_cnt == '1) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB;
            clr_cnt     <= '0;
            last_grant1 <= 1'b1;
            wrt_en      <= 1'b0;
            rd          <= '0;
            wrt_data    <= '0;
        end else begin
            state       <= state_next;
            clr_cnt     <= clr_cnt_next;
            last_grant1 <= last_grant1_next;
            wrt_en      <= wrt_en_next;
            rd          <= rd_next;
            wrt_data    <= wrt_data_next;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a bench-side round-robin model predicts grants
// and queues expected register-file writes; a monitor pops them the cycle after.
module tb_rf_wr_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req1_valid = 1'b0;
    logic          req0_ready;
    logic          req1_ready;
    logic [AW-1:0] req0_rd = '0;
    logic [AW-1:0] req1_rd = '0;
    logic [DW-1:0] req0_data = '0;
    logic [DW-1:0] req1_data = '0;
    logic          clear_start = 1'b0;
    logic          clear_busy;
    logic          wrt_en;
    logic [AW-1:0] rd;
    logic [DW-1:0] wrt_data;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_rd    (req0_rd),
        .req1_rd    (req1_rd),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .wrt_en     (wrt_en),
        .rd         (rd),
        .wrt_data   (wrt_data)
    );

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic rr_last = 1'b1;   // 1: req1 was granted most recently

    // Write-port monitor: every queued write must appear exactly one cycle later.
    initial forever begin
        logic exp_en;
        wr_t  e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            exp_en = (exp_q.size() != 0);
            e      = '0;
            if (exp_en) e = exp_q.pop_front();
            checks++;
            if (wrt_en !== exp_en) begin
                errors++;
                $display("FAIL wrt_en: got %b want %b at %0t", wrt_en, exp_en, $time);
            end else if (exp_en) begin
                checks++;
                if ({rd, wrt_data} !== e) begin
                    errors++;
                    $display("FAIL write: got rd=%0d data=%h want rd=%0d data=%h at %0t",
                             rd, wrt_data, e.rd, e.data, $time);
                end
            end
        end
    end

    function automatic logic [1:0] model_grant(input logic v0, input logic v1);
        logic g0, g1;
        g0 = v0 && (!v1 || rr_last);
        g1 = v1 && (!v0 || !rr_last);
        return {g1, g0};
    endfunction

    task automatic push_req(input wr_t w);
`ifdef RF_ARB_R0_ZERO_EN
        if (w.rd != '0) exp_q.push_back(w);
`else
        exp_q.push_back(w);
`endif
    endtask

    task automatic model_accept(input logic [1:0] g, input wr_t w0, input wr_t w1);
        if (g[0]) begin
            push_req(w0);
            rr_last = 1'b0;
        end
        if (g[1]) begin
            push_req(w1);
            rr_last = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v0, input logic v1, input wr_t w0, input wr_t w1,
                         input logic cs);
        req0_valid  = v0;
        req1_valid  = v1;
        req0_rd     = w0.rd;
        req0_data   = w0.data;
        req1_rd     = w1.rd;
        req1_data   = w1.data;
        clear_start = cs;
    endtask

    task automatic test_reset();
        wr_t w0, w1;
        w0 = {4'd1, 32'h1111_1111};
        w1 = {4'd2, 32'h2222_2222};
        reset = 1'b1;
        drive(1'b1, 1'b1, w0, w1, 1'b0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, clear_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got r1=%b r0=%b busy=%b want 000",
                     req1_ready, req0_ready, clear_busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({wrt_en, rd, wrt_data} !== '0) begin
            errors++;
            $display("FAIL reset_wr_port: got en=%b rd=%0d data=%h want 0/0/0",
                     wrt_en, rd, wrt_data);
        end
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, w0, w1, 1'b0);
        rr_last = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_round_robin();
        wr_t w0, w1;
        logic [1:0] g;
        w0 = {4'd3, 32'hA0A0_0003};
        w1 = {4'd5, 32'hB0B0_0005};
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 1'b1, w0, w1, 1'b0);
            @(negedge clk);
            g = model_grant(1'b1, 1'b1);
            checks++;
            if ({req1_ready, req0_ready} !== g) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, g);
            end
            model_accept(g, w0, w1);
        end
    endtask

    task automatic test_single();
        wr_t w0, w1;
        logic [1:0] g;
        w0 = '0;
        w1 = {4'd7, 32'hDEAD_BEEF};
        step();
        drive(1'b0, 1'b1, w0, w1, 1'b0);
        @(negedge clk);
        g = model_grant(1'b0, 1'b1);
        checks++;
        if ({req1_ready, req0_ready} !== g) begin
            errors++;
            $display("FAIL single_req1: got %b want %b", {req1_ready, req0_ready}, g);
        end
        model_accept(g, w0, w1);
        step();
        drive(1'b0, 1'b0, w0, w1, 1'b0);
    endtask

    task automatic test_back_to_back();
        wr_t w0, w1;
        logic [1:0] g;
        w1 = '0;
        for (int i = 0; i < 3; i++) begin
            w0 = {4'(9 + i), 32'(32'hC000_0000 + i)};
            step();
            drive(1'b1, 1'b0, w0, w1, 1'b0);
            @(negedge clk);
            g = model_grant(1'b1, 1'b0);
            checks++;
            if ({req1_ready, req0_ready} !== g) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, g);
            end
            model_accept(g, w0, w1);
        end
        step();
        drive(1'b0, 1'b0, w0, w1, 1'b0);
    endtask

    task automatic test_clear();
        wr_t w0, w1;
        logic [1:0] g;
        w0 = {4'd4, 32'h4444_0004};
        w1 = {4'd6, 32'h6666_0006};
        step();
        drive(1'b1, 1'b1, w0, w1, 1'b1);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, clear_busy} !== 3'b000) begin
            errors++;
            $display("FAIL clear_start_cycle: got r1=%b r0=%b busy=%b want 000",
                     req1_ready, req0_ready, clear_busy);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            step();
            drive(1'b1, 1'b1, w0, w1, i == 5);
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready, clear_busy} !== 3'b001) begin
                errors++;
                $display("FAIL clear_cycle[%0d]: got r1=%b r0=%b busy=%b want 001",
                         i, req1_ready, req0_ready, clear_busy);
            end
            exp_q.push_back({4'(i), 32'h0});
        end
        step();
        drive(1'b1, 1'b1, w0, w1, 1'b0);
        @(negedge clk);
        g = model_grant(1'b1, 1'b1);
        checks++;
        if ({req1_ready, req0_ready, clear_busy} !== {g, 1'b0}) begin
            errors++;
            $display("FAIL after_clear: got r1=%b r0=%b busy=%b want %b0",
                     req1_ready, req0_ready, clear_busy, g);
        end
        model_accept(g, w0, w1);
        step();
        drive(1'b0, 1'b0, w0, w1, 1'b0);
    endtask

    task automatic test_clear_reset();
        wr_t w0, w1;
        logic [1:0] g;
        w0 = {4'd2, 32'h0202_0202};
        w1 = {4'd8, 32'h0808_0808};
        step();
        drive(1'b0, 1'b0, w0, w1, 1'b1);
        for (int unsigned i = 0; i < 7; i++) begin
            step();
            drive(1'b0, 1'b0, w0, w1, 1'b0);
            exp_q.push_back({4'(i), 32'h0});
        end
        // The clear write for rd=6 is on the port in this cycle.
        step();
        reset = 1'b1;
        drive(1'b1, 1'b1, w0, w1, 1'b0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, clear_busy} !== 3'b000) begin
            errors++;
            $display("FAIL clear_reset_cycle: got r1=%b r0=%b busy=%b want 000",
                     req1_ready, req0_ready, clear_busy);
        end
        rr_last = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b1, 1'b1, w0, w1, 1'b0);
        @(negedge clk);
        g = model_grant(1'b1, 1'b1);
        checks++;
        if ({req1_ready, req0_ready, clear_busy} !== {g, 1'b0}) begin
            errors++;
            $display("FAIL after_clear_reset: got r1=%b r0=%b busy=%b want %b0",
                     req1_ready, req0_ready, clear_busy, g);
        end
        model_accept(g, w0, w1);
        step();
        drive(1'b0, 1'b0, w0, w1, 1'b0);
    endtask

    task automatic test_r0();
        wr_t w0, w1;
        logic [1:0] g;
        w0 = {4'd0, 32'h0000_0001};
        w1 = {4'd10, 32'h0A0A_0A0A};
        step();
        drive(1'b1, 1'b0, w0, w1, 1'b0);
        @(negedge clk);
        g = model_grant(1'b1, 1'b0);
        checks++;
        if ({req1_ready, req0_ready} !== g) begin
            errors++;
            $display("FAIL r0_grant: got %b want %b", {req1_ready, req0_ready}, g);
        end
        model_accept(g, w0, w1);
        w0 = {4'd11, 32'h0B0B_0B0B};
        step();
        drive(1'b1, 1'b1, w0, w1, 1'b0);
        @(negedge clk);
        g = model_grant(1'b1, 1'b1);
        checks++;
        if ({req1_ready, req0_ready} !== g) begin
            errors++;
            $display("FAIL r0_pointer: got %b want %b", {req1_ready, req0_ready}, g);
        end
        model_accept(g, w0, w1);
        step();
        drive(1'b0, 1'b0, w0, w1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_back_to_back();
        test_clear();
        test_clear_reset();
        test_r0();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending writes want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 4, register address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, write data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  write request pending.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-007 SHALL have ports req0_rd / req1_rd  input  ADDR_LEN each  destination register.
REQ-008 SHALL have ports req0_data / req1_data  input  DATA_LEN each  write data.
REQ-009 SHALL have port clear_start  input  1  pulse requesting a zero-fill of all registers.
REQ-010 SHALL have port clear_busy  output  1  high while the clear sequence runs.
REQ-011 SHALL have ports wrt_en (1), rd (ADDR_LEN), wrt_data (DATA_LEN)  output  the register file write port.

Function
REQ-012 SHALL implement a two-state FSM: ARB (normal arbitration) and CLEAR (zero-fill).
REQ-013 In ARB, reqN_ready SHALL be a combinational function of the valids, state, clear_start and the round-robin pointer; a transfer occurs when reqN_valid and reqN_ready are both 1.
REQ-014 In ARB with exactly one valid, that requester SHALL be granted.
REQ-015 In ARB with both valid, the requester not granted most recently SHALL be granted; at most one ready is high per cycle.
REQ-016 The round-robin pointer SHALL update only on a completed transfer.
REQ-017 wrt_en, rd and wrt_data SHALL be registered: a transfer at edge T SHALL produce wrt_en=1 with that rd/data for exactly the cycle after T.
REQ-018 wrt_en SHALL be 0 in any cycle following an edge with no transfer and no clear write.
REQ-019 A transfer SHALL be sustainable every cycle (throughput of 1 write per cycle).
REQ-020 clear_start=1 in ARB SHALL move the FSM to CLEAR at the next edge, with the clear counter set to 0; both readies SHALL be 0 in that cycle (clear outranks requests).
REQ-021 In CLEAR, each edge SHALL register wrt_en=1, rd=counter, wrt_data=0 and increment the counter; readies SHALL be 0; clear_busy SHALL be 1.
REQ-022 After registering the write for address 2^ADDR_LEN-1, the FSM SHALL return to ARB; exactly 2^ADDR_LEN writes are issued, in ascending address order.
REQ-023 clear_start SHALL be ignored while in CLEAR.
REQ-024 Requesters SHALL hold valid/rd/data stable until accepted; the block SHALL NOT drop or duplicate an accepted request.

Reset
REQ-025 reset SHALL force, at the next edge: FSM=ARB, clear counter=0, wrt_en=0, rd=0, wrt_data=0, pointer such that req0 wins the first contention.
REQ-026 While reset is high, req0_ready, req1_ready and clear_busy SHALL be 0.
REQ-027 reset asserted mid-CLEAR SHALL abort the sequence; no further clear writes are issued.

Configuration
REQ-028 With macro RF_ARB_R0_ZERO_EN defined, an accepted request with rd=0 SHALL complete its handshake and update the pointer but SHALL produce wrt_en=0; clear writes to address 0 are still issued.
REQ-029 Without RF_ARB_R0_ZERO_EN, rd=0 requests SHALL be written like any other address.

Verification
REQ-030 After reset, req0 and req1 both valid for 4 cycles (rd 3/5) -> grants 0,1,0,1; wrt_en every cycle from cycle 2, rd sequence 3,5,3,5.
REQ-031 Only req1 valid, rd=7, data=0xDEADBEEF -> req1_ready=1 same cycle; next cycle wrt_en=1, rd=7, wrt_data=0xDEADBEEF.
REQ-032 clear_start pulse with both requests valid -> readies 0; clear_busy high 16 cycles; wrt_en=1, wrt_data=0 for rd 0..15; pending requests accepted only after return to ARB.
REQ-033 reset asserted at clear write rd=6 -> next cycle wrt_en=0, clear_busy=0, FSM in ARB, req0 wins next contention.
REQ-034 req0 rd=0 data=0x1 accepted -> with RF_ARB_R0_ZERO_EN wrt_en stays 0; without it wrt_en=1, rd=0, wrt_data=0x1.
